// File: rtl/tmr_vote_pkg.sv
// rtl/tmr_vote_pkg.sv - shared lane codes, FSM state type and lane classifier
package tmr_vote_pkg;

    typedef enum logic [1:0] {
        LANE_MULTI = 2'd0,
        LANE_A     = 2'd1,
        LANE_B     = 2'd2,
        LANE_C     = 2'd3
    } lane_e;

    typedef enum logic {
        ST_IDLE,
        ST_REPORT
    } state_e;

    // A single disagreeing copy is named; outliers spread over several copies
    // (in different bits) collapse to LANE_MULTI.
    function automatic lane_e lane_of(input logic hit_a, input logic hit_b, input logic hit_c);
        case ({hit_a, hit_b, hit_c})
            3'b100:  return LANE_A;
            3'b010:  return LANE_B;
            3'b001:  return LANE_C;
            default: return LANE_MULTI;
        endcase
    endfunction

endpackage

// File: rtl/tmr_vote_core.sv
// rtl/tmr_vote_core.sv - combinational bitwise majority vote with per-copy outlier masks
// Ports:
//   in_a/in_b/in_c : the three copies
//   maj            : bitwise majority
//   d_a/d_b/d_c    : bits where each copy disagrees with the majority
module tmr_vote_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    output logic [WIDTH-1:0] maj,
    output logic [WIDTH-1:0] d_a,
    output logic [WIDTH-1:0] d_b,
    output logic [WIDTH-1:0] d_c
);

    assign maj = (in_a & in_b) | (in_a & in_c) | (in_b & in_c);
    assign d_a = in_a ^ maj;
    assign d_b = in_b ^ maj;
    assign d_c = in_c ^ maj;

endmodule

// File: rtl/tmr_vote_scrubber.sv
// rtl/tmr_vote_scrubber.sv - TMR voter with per-lane refresh strobes and error reporting
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   in_a/in_b/in_c          : triplicated state copies
//   voted_out               : registered majority
//   fix_a/fix_b/fix_c       : one-cycle reload strobes per copy
//   err_valid/err_ready     : error report handshake
//   err_lane/err_mask       : report payload (lane code, disagreeing bits)
//   err_count               : saturating count of mismatch cycles
//   err_lost                : sticky, event dropped while a report was pending
//   err_clr                 : clears err_count and err_lost
module tmr_vote_scrubber
    import tmr_vote_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    output logic [WIDTH-1:0] voted_out,
    output logic             fix_a,
    output logic             fix_b,
    output logic             fix_c,
    output logic             err_valid,
    input  logic             err_ready,
    output logic [1:0]       err_lane,
    output logic [WIDTH-1:0] err_mask,
    output logic [CNT_W-1:0] err_count,
    output logic             err_lost,
    input  logic             err_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] maj, d_a, d_b, d_c;
    logic             mism;
    lane_e            lane_now;

    state_e state, state_next;
    logic   capture;
    logic   set_lost;

    tmr_vote_core #(.WIDTH(WIDTH)) u_core (
        .in_a (in_a),
        .in_b (in_b),
        .in_c (in_c),
        .maj  (maj),
        .d_a  (d_a),
        .d_b  (d_b),
        .d_c  (d_c)
    );

    assign mism     = |(d_a | d_b | d_c);
    assign lane_now = lane_of(|d_a, |d_b, |d_c);

    assign err_valid = (state == ST_REPORT);

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        set_lost   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mism) begin
                    state_next = ST_REPORT;
                    capture    = 1'b1;
                end
            end
            ST_REPORT: begin
                if (err_ready) begin
                    // Accepting and re-arming in the same cycle avoids a bubble
                    // between back-to-back reports.
                    capture    = mism;
                    state_next = mism ? ST_REPORT : ST_IDLE;
                end else if (mism) begin
                    set_lost = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            voted_out <= '0;
            fix_a     <= 1'b0;
            fix_b     <= 1'b0;
            fix_c     <= 1'b0;
            err_lane  <= LANE_MULTI;
            err_mask  <= '0;
            err_count <= '0;
            err_lost  <= 1'b0;
        end else begin
            state     <= state_next;
            voted_out <= maj;
            // Repair is independent of the report channel: every mismatch
            // cycle refreshes the offending copies even if the report is lost.
            fix_a     <= |d_a;
            fix_b     <= |d_b;
            fix_c     <= |d_c;
            if (capture) begin
                err_lane <= lane_now;
                err_mask <= d_a | d_b | d_c;
            end
            if (err_clr) begin
                err_count <= '0;
                err_lost  <= 1'b0;
            end else begin
                if (mism && err_count != CNT_MAX) begin
                    err_count <= err_count + CNT_ONE;
                end
                if (set_lost) begin
                    err_lost <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tmr_vote_scrubber.sv
// tb/tb_tmr_vote_scrubber.sv - self-checking bench for tmr_vote_scrubber
module tb_tmr_vote_scrubber;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_a, in_b, in_c;
    logic       err_ready, err_clr;

    logic [7:0] voted_out, err_mask;
    logic       fix_a, fix_b, fix_c, err_valid, err_lost;
    logic [1:0] err_lane;
    logic [7:0] err_count;

    logic [7:0] voted_out2, err_mask2;
    logic       fix_a2, fix_b2, fix_c2, err_valid2, err_lost2;
    logic [1:0] err_lane2;
    logic [1:0] err_count2;

    tmr_vote_scrubber #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .voted_out(voted_out), .fix_a(fix_a), .fix_b(fix_b), .fix_c(fix_c),
        .err_valid(err_valid), .err_ready(err_ready), .err_lane(err_lane),
        .err_mask(err_mask), .err_count(err_count), .err_lost(err_lost),
        .err_clr(err_clr)
    );

    tmr_vote_scrubber #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .voted_out(voted_out2), .fix_a(fix_a2), .fix_b(fix_b2), .fix_c(fix_c2),
        .err_valid(err_valid2), .err_ready(err_ready), .err_lane(err_lane2),
        .err_mask(err_mask2), .err_count(err_count2), .err_lost(err_lost2),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_voted, m_mask;
    logic       m_fa, m_fb, m_fc, m_valid, m_lost;
    logic [1:0] m_lane;
    int         m_cnt, m_cnt2;

    // Applies one clock edge with the currently driven inputs and advances
    // the model; returns 1 time unit after the edge.
    task automatic tick();
        logic [7:0] mj, da, db, dc;
        int         ones, nl;
        logic [1:0] ln;
        bit         mism, hs, lose;
        for (int i = 0; i < 8; i++) begin
            ones  = int'(in_a[i]) + int'(in_b[i]) + int'(in_c[i]);
            mj[i] = (ones >= 2);
            da[i] = (in_a[i] != mj[i]);
            db[i] = (in_b[i] != mj[i]);
            dc[i] = (in_c[i] != mj[i]);
        end
        nl = int'(|da) + int'(|db) + int'(|dc);
        if (nl != 1)  ln = 2'd0;
        else if (|da) ln = 2'd1;
        else if (|db) ln = 2'd2;
        else          ln = 2'd3;
        mism = |(da | db | dc);
        hs   = m_valid && err_ready;
        lose = mism && m_valid && !hs;
        @(posedge clk);
        #1;
        if (rst) begin
            m_voted = 0; m_mask = 0; m_lane = 0;
            m_fa = 0; m_fb = 0; m_fc = 0; m_valid = 0; m_lost = 0;
            m_cnt = 0; m_cnt2 = 0;
        end else begin
            m_voted = mj;
            m_fa = |da; m_fb = |db; m_fc = |dc;
            if (mism && (!m_valid || hs)) begin
                m_valid = 1; m_lane = ln; m_mask = da | db | dc;
            end else if (hs) begin
                m_valid = 0;
            end
            if (err_clr) begin
                m_cnt = 0; m_cnt2 = 0; m_lost = 0;
            end else begin
                if (mism && m_cnt < 255) m_cnt++;
                if (mism && m_cnt2 < 3) m_cnt2++;
                if (lose) m_lost = 1;
            end
        end
    endtask

    task automatic set_in(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        in_a = a; in_b = b; in_c = c;
    endtask

    task automatic test_reset();
        rst = 1; err_ready = 1'($urandom); err_clr = 0;
        for (int i = 0; i < 2; i++) begin
            set_in(8'($urandom), 8'($urandom), 8'($urandom));
            tick();
        end
        n_checks++; if (voted_out !== 8'h00) begin n_fail++; $display("FAIL reset_voted got=%h exp=00", voted_out); end
        n_checks++; if ({fix_a, fix_b, fix_c} !== 3'b000) begin n_fail++; $display("FAIL reset_fix got=%b exp=000", {fix_a, fix_b, fix_c}); end
        n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", err_valid); end
        n_checks++; if ({err_lane, err_mask} !== 10'h000) begin n_fail++; $display("FAIL reset_payload got=%h exp=000", {err_lane, err_mask}); end
        n_checks++; if ({err_count, err_lost, err_count2} !== 11'h000) begin n_fail++; $display("FAIL reset_count got=%h exp=000", {err_count, err_lost, err_count2}); end
        rst = 0;
    endtask

    task automatic test_match();
        err_ready = 0;
        set_in(8'h5A, 8'h5A, 8'h5A);
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({voted_out, fix_a, fix_b, fix_c, err_valid, err_count} !== {8'h5A, 4'b0000, 8'h00}) begin
                n_fail++;
                $display("FAIL match cyc=%0d got voted=%h fix=%b valid=%b cnt=%0d exp voted=5a fix=000 valid=0 cnt=0",
                         i, voted_out, {fix_a, fix_b, fix_c}, err_valid, err_count);
            end
        end
    endtask

    task automatic test_single_lane();
        err_ready = 1;
        set_in(8'h5B, 8'h5A, 8'h5A);
        tick();
        n_checks++; if (voted_out !== 8'h5A) begin n_fail++; $display("FAIL single_voted got=%h exp=5a", voted_out); end
        n_checks++; if ({fix_a, fix_b, fix_c} !== 3'b100) begin n_fail++; $display("FAIL single_fix got=%b exp=100", {fix_a, fix_b, fix_c}); end
        n_checks++; if ({err_valid, err_lane, err_mask} !== {1'b1, 2'd1, 8'h01}) begin n_fail++; $display("FAIL single_report got v=%b l=%0d m=%h exp v=1 l=1 m=01", err_valid, err_lane, err_mask); end
        n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", err_count); end
        set_in(8'h5A, 8'h5A, 8'h5A);
        tick();
        n_checks++; if ({fix_a, err_valid, err_count} !== {1'b0, 1'b0, 8'd1}) begin n_fail++; $display("FAIL single_after got fix_a=%b v=%b cnt=%0d exp 0 0 1", fix_a, err_valid, err_count); end
    endtask

    task automatic test_multi_lane();
        err_ready = 1;
        set_in(8'h5B, 8'h7A, 8'h5A);
        tick();
        n_checks++; if ({fix_a, fix_b, fix_c} !== 3'b110) begin n_fail++; $display("FAIL multi_fix got=%b exp=110", {fix_a, fix_b, fix_c}); end
        n_checks++; if ({err_valid, err_lane, err_mask} !== {1'b1, 2'd0, 8'h21}) begin n_fail++; $display("FAIL multi_report got v=%b l=%0d m=%h exp v=1 l=0 m=21", err_valid, err_lane, err_mask); end
        n_checks++; if (voted_out !== 8'h5A) begin n_fail++; $display("FAIL multi_voted got=%h exp=5a", voted_out); end
        set_in(8'h5A, 8'h5A, 8'h5A);
        tick();
    endtask

    task automatic test_lost();
        rst = 1; tick(); rst = 0;
        err_ready = 0;
        set_in(8'h5A, 8'h5E, 8'h5A);
        tick();
        set_in(8'h5A, 8'h5A, 8'hDA);
        tick();
        n_checks++; if ({err_valid, err_lane, err_mask} !== {1'b1, 2'd2, 8'h04}) begin n_fail++; $display("FAIL lost_payload got v=%b l=%0d m=%h exp v=1 l=2 m=04", err_valid, err_lane, err_mask); end
        n_checks++; if ({err_lost, fix_c} !== 2'b11) begin n_fail++; $display("FAIL lost_flag got lost=%b fix_c=%b exp 1 1", err_lost, fix_c); end
        n_checks++; if (err_count !== 8'd2) begin n_fail++; $display("FAIL lost_count got=%0d exp=2", err_count); end
        set_in(8'h5A, 8'h5A, 8'h5A);
        tick();
        n_checks++; if ({err_valid, err_lane} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL lost_hold got v=%b l=%0d exp v=1 l=2", err_valid, err_lane); end
        err_ready = 1;
        tick();
        n_checks++; if ({err_valid, err_lost} !== 2'b01) begin n_fail++; $display("FAIL lost_drain got v=%b lost=%b exp v=0 lost=1", err_valid, err_lost); end
    endtask

    task automatic test_saturate_clear();
        logic [7:0] base;
        rst = 1; tick(); rst = 0;
        err_ready = 0;
        for (int i = 0; i < 5; i++) begin
            base = 8'($urandom);
            set_in(base ^ 8'(1 << (i % 8)), base, base);
            tick();
        end
        n_checks++; if (err_count2 !== 2'd3) begin n_fail++; $display("FAIL sat_count2 got=%0d exp=3", err_count2); end
        n_checks++; if ({err_count, err_lost} !== {8'd5, 1'b1}) begin n_fail++; $display("FAIL sat_count got cnt=%0d lost=%b exp cnt=5 lost=1", err_count, err_lost); end
        err_clr = 1; err_ready = 1;
        set_in(8'h3C, 8'h3C, 8'h3D);
        tick();
        err_clr = 0;
        n_checks++; if ({err_count, err_count2, err_lost} !== 11'h000) begin n_fail++; $display("FAIL clr got cnt=%0d cnt2=%0d lost=%b exp 0 0 0", err_count, err_count2, err_lost); end
        n_checks++; if ({err_valid, err_lane, err_mask, fix_c} !== {1'b1, 2'd3, 8'h01, 1'b1}) begin n_fail++; $display("FAIL clr_report got v=%b l=%0d m=%h fix_c=%b exp v=1 l=3 m=01 fix_c=1", err_valid, err_lane, err_mask, fix_c); end
        set_in(8'h3C, 8'h3C, 8'h3C);
        tick();
    endtask

    task automatic test_random();
        logic [7:0] base;
        logic [10:0] got_p, exp_p, got_p2;
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom % 97) == 0;
            err_ready = 1'($urandom);
            err_clr   = ($urandom % 16) == 0;
            base      = 8'($urandom);
            case ($urandom % 4)
                0: set_in(base, base, base);
                1: set_in(base ^ 8'($urandom), base, base);
                2: set_in(base, base ^ 8'h0F, base ^ 8'hF0);
                default: set_in(8'($urandom), 8'($urandom), 8'($urandom));
            endcase
            tick();
            got_p  = err_valid  ? {1'b1, err_lane,  err_mask}  : 11'h0;
            got_p2 = err_valid2 ? {1'b1, err_lane2, err_mask2} : 11'h0;
            exp_p  = m_valid    ? {1'b1, m_lane,    m_mask}    : 11'h0;
            n_checks++;
            if ({voted_out, fix_a, fix_b, fix_c, got_p, err_count, err_lost} !==
                {m_voted, m_fa, m_fb, m_fc, exp_p, m_cnt[7:0], m_lost}) begin
                n_fail++;
                $display("FAIL rand cyc=%0d got v=%h f=%b p=%h c=%0d l=%b exp v=%h f=%b p=%h c=%0d l=%b",
                         i, voted_out, {fix_a, fix_b, fix_c}, got_p, err_count, err_lost,
                         m_voted, {m_fa, m_fb, m_fc}, exp_p, m_cnt, m_lost);
            end
            n_checks++;
            if ({voted_out2, fix_a2, fix_b2, fix_c2, got_p2, err_count2, err_lost2} !==
                {m_voted, m_fa, m_fb, m_fc, exp_p, m_cnt2[1:0], m_lost}) begin
                n_fail++;
                $display("FAIL rand2 cyc=%0d got v=%h p=%h c=%0d l=%b exp v=%h p=%h c=%0d l=%b",
                         i, voted_out2, got_p2, err_count2, err_lost2, m_voted, exp_p, m_cnt2, m_lost);
            end
        end
        rst = 0; err_clr = 0;
    endtask

    initial begin
        rst = 1; err_ready = 0; err_clr = 0;
        set_in(8'h00, 8'h00, 8'h00);
        m_voted = 0; m_mask = 0; m_lane = 0;
        m_fa = 0; m_fb = 0; m_fc = 0; m_valid = 0; m_lost = 0;
        m_cnt = 0; m_cnt2 = 0;
        test_reset();
        test_match();
        test_single_lane();
        test_multi_lane();
        test_lost();
        test_saturate_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
